// File: rtl/gpu_rect_fill_if.sv
// Bundle between the control slave, the rectangle fill engine and the framebuffer BRAM write port.
// The engine uses the slave view; the controller (or a bench) uses the master view.
interface gpu_rect_fill_if #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [9:0]                 cmd_x0;
    logic [9:0]                 cmd_y0;
    logic [9:0]                 cmd_w;
    logic [9:0]                 cmd_h;
    logic [FBUF_DATA_WIDTH-1:0] cmd_color;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic                       fbuf_en_wr;
    logic                       fbuf_wrea;
    logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
    logic [FBUF_DATA_WIDTH-1:0] fbuf_data;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, err, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, err, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
    );
endinterface

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine: takes one clipped fill command and writes one pixel per clock,
// row-major, into the framebuffer BRAM; reports done/err when the command retires.
module gpu_rect_fill #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8,
    parameter int FB_WIDTH        = 640,
    parameter int FB_HEIGHT       = 480
) (
    input logic            aclk,
    input logic            areset,
    gpu_rect_fill_if.slave bus
);
    localparam int AW = FBUF_ADDR_WIDTH;
    localparam int DW = FBUF_DATA_WIDTH;
    localparam logic [10:0]   FBW11 = 11'(FB_WIDTH);
    localparam logic [10:0]   FBH11 = 11'(FB_HEIGHT);
    localparam logic [AW-1:0] FBW_A = AW'(FB_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [DW-1:0] color_q, color_d;
    logic [10:0]   x_q, x_d, y_q, y_d, x_end_q, x_end_d, y_end_q, y_end_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          err_flag_q, err_flag_d;
    logic          cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic          done_q, done_d, err_q, err_d, wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          hs;
    logic [10:0]   x_sum, y_sum;

    always_comb begin
        hs          = (state_q == IDLE) && cmd_ready_q && bus.cmd_valid;
        x_sum       = {1'b0, x0_q} + {1'b0, w_q};
        y_sum       = {1'b0, y0_q} + {1'b0, h_q};
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x_d         = x_q;
        y_d         = y_q;
        x_end_d     = x_end_q;
        y_end_d     = y_end_q;
        row_base_d  = row_base_q;
        err_flag_d  = err_flag_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    x0_d    = bus.cmd_x0;
                    y0_d    = bus.cmd_y0;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                x_end_d    = (x_sum > FBW11) ? FBW11 : x_sum;
                y_end_d    = (y_sum > FBH11) ? FBH11 : y_sum;
                row_base_d = AW'(y0_q) * FBW_A;
                x_d        = {1'b0, x0_q};
                y_d        = {1'b0, y0_q};
                err_flag_d = ({1'b0, x0_q} >= FBW11) || ({1'b0, y0_q} >= FBH11);
                if (err_flag_d || w_q == 10'd0 || h_q == 10'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // Row stepping is an add of FB_WIDTH so the inner loop needs no multiplier.
                wr_d   = 1'b1;
                addr_d = row_base_q + AW'(x_q);
                data_d = color_q;
                if (x_q == x_end_q - 11'd1) begin
                    x_d        = {1'b0, x0_q};
                    y_d        = y_q + 11'd1;
                    row_base_d = row_base_q + FBW_A;
                    if (y_q == y_end_q - 11'd1) begin
                        state_d = DONE;
                    end
                end else begin
                    x_d = x_q + 11'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                err_d   = err_flag_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from this cycle's decision.
        cmd_ready_d = (state_q == IDLE) && !hs;
        busy_d      = (state_q != IDLE) || hs;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge aclk) begin
        x0_q       <= x0_d;
        y0_q       <= y0_d;
        w_q        <= w_d;
        h_q        <= h_d;
        color_q    <= color_d;
        x_q        <= x_d;
        y_q        <= y_d;
        x_end_q    <= x_end_d;
        y_end_q    <= y_end_d;
        row_base_q <= row_base_d;
        err_flag_q <= err_flag_d;
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.fbuf_en_wr = wr_q;
    assign bus.fbuf_wrea  = wr_q;
    assign bus.fbuf_addr  = addr_q;
    assign bus.fbuf_data  = data_q;
endmodule
